// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic phase controller.
//   tlc_state_t : controller state encoding (GREEN, YELLOW, ALLRED, FLASH)
//   SEC_W       : width of every seconds quantity (sec_left, elapsed, loads)
//   sat_inc     : saturating seconds increment
//   min1        : maps a programmed duration of 0 to 1 second
package tlc_pkg;

  localparam int SEC_W = 8;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2,
    FLASH  = 2'd3
  } tlc_state_t;

  function automatic logic [SEC_W-1:0] sat_inc(input logic [SEC_W-1:0] v);
    return (v == {SEC_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [SEC_W-1:0] min1(input logic [SEC_W-1:0] v);
    return (v == '0) ? SEC_W'(1) : v;
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// One-second tick prescaler.
//   clk  : clock
//   rst  : synchronous active-high reset
//   clr  : restart the prescaler (asserted on the edge that enters a new state)
//   tick : high during the last cycle of every UCY-cycle window
module tlc_tick_gen #(
  parameter int UCY = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (UCY > 1) ? $clog2(UCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(UCY - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Tick in cycle UCY-1 of the window, so a transition taken on it makes
  // the state last exactly UCY cycles per second.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic signal phase controller.
// Cycles phases 0..NPH-1, each as GREEN -> YELLOW -> ALLRED (ALLRED skipped
// when CLR_S = 0). A manual-advance input N shortens GREEN once the minimum
// green time MIN_S has elapsed.
// Optional build macro TLC_FLASH_EN adds the flash input (flashing yellow,
// timers frozen, resumes into the current phase's GREEN).
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset (phase 0 GREEN)
//   N        : asynchronous manual-advance request (rising edge)
//   flash    : (TLC_FLASH_EN only) flashing-yellow mode
//   grn_sec  : per-phase green seconds, phase p in [8p+7:8p]
//   grn, yel : registered one-hot green / yellow lamps
//   phase    : current phase index
//   sec_left : seconds remaining in the current state
module traffic_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int NPH   = 3,
  parameter int UCY   = 1000,
  parameter int YEL_S = 3,
  parameter int CLR_S = 1,
  parameter int MIN_S = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     N,
`ifdef TLC_FLASH_EN
  input  logic                     flash,
`endif
  input  logic [NPH*8-1:0]         grn_sec,
  output logic [NPH-1:0]           grn,
  output logic [NPH-1:0]           yel,
  output logic [$clog2(NPH)-1:0]   phase,
  output logic [7:0]               sec_left
);

  localparam int PW = $clog2(NPH);
  localparam logic [PW-1:0]    LAST_PH = PW'(NPH - 1);
  localparam logic [SEC_W-1:0] ONE     = SEC_W'(1);
  localparam logic [SEC_W-1:0] YEL_V   = SEC_W'(YEL_S);
  localparam logic [SEC_W-1:0] CLR_V   = SEC_W'(CLR_S);
  localparam logic [SEC_W-1:0] MIN_V   = (MIN_S > 255) ? 8'd255 : SEC_W'(MIN_S);

  tlc_state_t       state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d, phase_nx;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [SEC_W-1:0] elap_q, elap_d, elap_inc;
  logic             latch_q, latch_d;
  logic             go_yel;
  logic             n_p0, n_p1, n_p2, req_p3;
  logic [NPH-1:0]   grn_q, yel_q, grn_d, yel_d;
  logic             tick, clr;

  function automatic logic [SEC_W-1:0] grn_load(input logic [PW-1:0] p);
    return min1(grn_sec[SEC_W*int'(p) +: SEC_W]);
  endfunction

  tlc_tick_gen #(.UCY(UCY)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign phase_nx = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
  assign elap_inc = sat_inc(elap_q);
  assign clr      = (state_d != state_q);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sec_d   = sec_q;
    elap_d  = elap_q;
    latch_d = latch_q;
    go_yel  = 1'b0;
`ifdef TLC_FLASH_EN
    if (flash) begin
      state_d = FLASH;
      latch_d = 1'b0;
    end else
`endif
    begin
      unique case (state_q)
        GREEN: begin
          // Timeout is tested first so a coincident request cannot cause a
          // second transition; the latch is dropped on exit regardless.
          if (tick && sec_q == ONE) begin
            go_yel = 1'b1;
          end else if (req_p3 && elap_q >= MIN_V) begin
            go_yel = 1'b1;
          end else if (tick && (latch_q || req_p3) && elap_inc >= MIN_V) begin
            go_yel = 1'b1;
          end else begin
            if (tick) begin
              sec_d  = sec_q - 1'b1;
              elap_d = elap_inc;
            end
            if (req_p3) begin
              latch_d = 1'b1;
            end
          end
          if (go_yel) begin
            state_d = YELLOW;
            sec_d   = YEL_V;
            elap_d  = '0;
            latch_d = 1'b0;
          end
        end
        YELLOW: begin
          if (tick) begin
            if (sec_q == ONE) begin
              if (CLR_S == 0) begin
                state_d = GREEN;
                phase_d = phase_nx;
                sec_d   = grn_load(phase_nx);
                elap_d  = '0;
              end else begin
                state_d = ALLRED;
                sec_d   = CLR_V;
              end
            end else begin
              sec_d = sec_q - 1'b1;
            end
          end
        end
        ALLRED: begin
          if (tick) begin
            if (sec_q == ONE) begin
              state_d = GREEN;
              phase_d = phase_nx;
              sec_d   = grn_load(phase_nx);
              elap_d  = '0;
            end else begin
              sec_d = sec_q - 1'b1;
            end
          end
        end
`ifdef TLC_FLASH_EN
        FLASH: begin
          state_d = GREEN;
          sec_d   = grn_load(phase_q);
          elap_d  = '0;
          latch_d = 1'b0;
        end
`endif
        default: begin
          state_d = GREEN;
          phase_d = '0;
          sec_d   = grn_load('0);
          elap_d  = '0;
          latch_d = 1'b0;
        end
      endcase
    end
  end

  // Lamp decode from the next state, registered below
  always_comb begin
    grn_d = '0;
    yel_d = '0;
    unique case (state_d)
      GREEN:   grn_d[phase_d] = 1'b1;
      YELLOW:  yel_d[phase_d] = 1'b1;
`ifdef TLC_FLASH_EN
      FLASH: begin
        if (state_q != FLASH) begin
          yel_d = '1;
        end else if (tick) begin
          yel_d = ~yel_q;
        end else begin
          yel_d = yel_q;
        end
      end
`endif
      default: ;
    endcase
  end

  // State register, request synchroniser and lamp registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GREEN;
      phase_q <= '0;
      sec_q   <= grn_load('0);
      elap_q  <= '0;
      latch_q <= 1'b0;
      grn_q   <= NPH'(1);
      yel_q   <= '0;
      n_p0    <= 1'b0;
      n_p1    <= 1'b0;
      n_p2    <= 1'b0;
      req_p3  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sec_q   <= sec_d;
      elap_q  <= elap_d;
      latch_q <= latch_d;
      grn_q   <= grn_d;
      yel_q   <= yel_d;
      // 2-flop synchroniser, then registered rising-edge detect
      n_p0    <= N;
      n_p1    <= n_p0;
      n_p2    <= n_p1;
      req_p3  <= n_p1 & ~n_p2;
    end
  end

  assign grn      = grn_q;
  assign yel      = yel_q;
  assign phase    = phase_q;
  assign sec_left = sec_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with NPH=3, UCY=4, YEL_S=2,
// CLR_S=1, MIN_S=2. grn_sec = {3,2,5} gives phase 0/1/2 greens of 5/2/3 s.
module tb_traffic_phase_ctrl;

  logic        clk;
  logic        rst;
  logic        N;
  logic [23:0] grn_sec;
  logic [2:0]  grn;
  logic [2:0]  yel;
  logic [1:0]  phase;
  logic [7:0]  sec_left;

  int n_cmp;
  int n_err;

  traffic_phase_ctrl #(
    .NPH   (3),
    .UCY   (4),
    .YEL_S (2),
    .CLR_S (1),
    .MIN_S (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .N        (N),
    .grn_sec  (grn_sec),
    .grn      (grn),
    .yel      (yel),
    .phase    (phase),
    .sec_left (sec_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts cycles the lamps hold pattern g/y, starting at the current cycle.
  task automatic measure(input string tag, input logic [2:0] g, input logic [2:0] y,
                         input int exp);
    int n;
    n = 0;
    while (grn === g && yel === y && n < 200) begin
      n++;
      step();
    end
    chk(tag, n, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    N       = 1'b0;
    grn_sec = {8'd3, 8'd2, 8'd5};

    // Reset state and free run
    do_reset();
    chk("rst_grn", grn, 3'b001);
    chk("rst_yel", yel, 3'b000);
    chk("rst_phase", phase, 0);
    chk("rst_sec", sec_left, 5);
    measure("run_g0", 3'b001, 3'b000, 20);
    chk("run_y0_sec", sec_left, 2);
    measure("run_y0", 3'b000, 3'b001, 8);
    measure("run_ar0", 3'b000, 3'b000, 4);
    chk("run_g1_phase", phase, 1);
    chk("run_g1_sec", sec_left, 2);
    measure("run_g1", 3'b010, 3'b000, 8);

    // Early request: held until elapsed reaches MIN_S
    do_reset();
    step();
    step();
    N = 1'b1;
    step();
    N = 1'b0;
    chk("early_sec3", sec_left, 5);
    measure("early_g0", 3'b001, 3'b000, 5);
    chk("early_yel", yel, 3'b001);
    chk("early_sec_y", sec_left, 2);

    // Late request: yellow 4 cycles after N
    do_reset();
    for (int i = 0; i < 12; i++) step();
    N = 1'b1;
    step();
    N = 1'b0;
    measure("late_g0", 3'b001, 3'b000, 3);

    // Request during yellow is discarded
    step();
    N = 1'b1;
    step();
    step();
    N = 1'b0;
    measure("ign_y0", 3'b000, 3'b001, 5);
    measure("ign_ar0", 3'b000, 3'b000, 4);
    chk("ign_g1_phase", phase, 1);
    measure("ign_g1", 3'b010, 3'b000, 8);

    // Request coinciding with timeout: one transition, nothing carried
    do_reset();
    for (int i = 0; i < 16; i++) step();
    N = 1'b1;
    step();
    N = 1'b0;
    measure("coin_g0", 3'b001, 3'b000, 3);
    measure("coin_y0", 3'b000, 3'b001, 8);
    measure("coin_ar0", 3'b000, 3'b000, 4);
    measure("coin_g1", 3'b010, 3'b000, 8);

    // Zero green seconds treated as one second
    grn_sec = {8'd3, 8'd2, 8'd0};
    do_reset();
    chk("zero_sec", sec_left, 1);
    measure("zero_g0", 3'b001, 3'b000, 4);
    measure("zero_y0", 3'b000, 3'b001, 8);

    // Reset during phase-1 ALLRED
    grn_sec = {8'd3, 8'd2, 8'd5};
    do_reset();
    measure("ab_g0", 3'b001, 3'b000, 20);
    measure("ab_y0", 3'b000, 3'b001, 8);
    measure("ab_ar0", 3'b000, 3'b000, 4);
    measure("ab_g1", 3'b010, 3'b000, 8);
    chk("ab_y1_phase", phase, 1);
    measure("ab_y1", 3'b000, 3'b010, 8);
    step();
    rst = 1'b1;
    step();
    chk("ab_phase", phase, 0);
    chk("ab_grn", grn, 3'b001);
    chk("ab_yel", yel, 3'b000);
    chk("ab_sec", sec_left, 5);
    rst = 1'b0;
    measure("ab_g0_after", 3'b001, 3'b000, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
